// File: rtl/lsu_amo_engine.sv
// Load/store unit sequencer for loads, stores, LR/SC and AMO read-modify-write
// over a single-beat 64-bit bus with byte lane enables.
module lsu_amo_engine #(
    parameter int unsigned RSV_LSB = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [3:0]  size,
    input  logic        unsign,
    output logic [63:0] amo_mem,
    input  logic [63:0] amo_result,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [7:0]  bus_bsel,
    output logic [63:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        done,
    output logic [63:0] rd_data,
    output logic        misalign
);

    typedef enum logic [2:0] {IDLE, RD, AMO_CALC, WR, FIN} state_t;
    typedef enum logic [2:0] {
        OP_LOAD = 3'b000, OP_STORE = 3'b001, OP_LR = 3'b010,
        OP_SC = 3'b011, OP_AMO = 3'b100
    } op_t;

    state_t state, state_nxt;
    op_t    op_in, op_q;
    logic [63:0] addr_q, wval_q, rd_q;
    logic [3:0]  size_q;
    logic        unsign_q, err_q;
    logic        rsv_valid;
    logic [63:RSV_LSB] rsv_tag;

    logic [7:0]  in_mask, q_mask;
    logic [63:0] wmask, shifted, ext_data;
    logic        in_misal, sc_ok;

    // Unrecognised size encodings are treated as a full doubleword.
    function automatic logic [7:0] lane_mask(input logic [3:0] s);
        case (s)
            4'b0001: lane_mask = 8'h01;
            4'b0010: lane_mask = 8'h03;
            4'b0100: lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    endfunction

    assign op_in    = op_t'(op);
    assign in_mask  = lane_mask(size);
    assign q_mask   = lane_mask(size_q);
    assign in_misal = |(addr[2:0] & {in_mask[7], in_mask[3], in_mask[1]});
    assign sc_ok    = rsv_valid && (rsv_tag == addr[63:RSV_LSB]);

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < 8; i++)
            wmask[8*i +: 8] = {8{q_mask[i]}};
    end

    always_comb begin
        shifted = bus_rdata >> {addr_q[2:0], 3'b000};
        case (size_q)
            4'b0001: ext_data = {{56{~unsign_q & shifted[7]}},  shifted[7:0]};
            4'b0010: ext_data = {{48{~unsign_q & shifted[15]}}, shifted[15:0]};
            4'b0100: ext_data = {{32{~unsign_q & shifted[31]}}, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (in_misal) state_nxt = FIN;
                else case (op_in)
                    OP_LOAD, OP_LR, OP_AMO: state_nxt = RD;
                    OP_STORE:               state_nxt = WR;
                    OP_SC:                  state_nxt = sc_ok ? WR : FIN;
                    default:                state_nxt = FIN;
                endcase
            end
            RD:       if (bus_ack) state_nxt = (op_q == OP_AMO) ? AMO_CALC : FIN;
            AMO_CALC: state_nxt = WR;
            WR:       if (bus_ack) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= OP_LOAD;
            addr_q    <= '0;
            wval_q    <= '0;
            rd_q      <= '0;
            size_q    <= '0;
            unsign_q  <= 1'b0;
            err_q     <= 1'b0;
            rsv_valid <= 1'b0;
            rsv_tag   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q     <= op_in;
                    addr_q   <= addr;
                    wval_q   <= wdata;
                    size_q   <= size;
                    unsign_q <= unsign;
                    err_q    <= in_misal;
                    rd_q     <= {63'd0, (op_in == OP_SC) && !sc_ok};
                end
                RD:       if (bus_ack) rd_q <= ext_data;
                AMO_CALC: wval_q <= amo_result;
                FIN: if (!err_q) begin
                    // Reservation changes take effect when the operation retires.
                    case (op_q)
                        OP_LR: begin
                            rsv_valid <= 1'b1;
                            rsv_tag   <= addr_q[63:RSV_LSB];
                        end
                        OP_SC: rsv_valid <= 1'b0;
                        OP_STORE, OP_AMO:
                            if (rsv_tag == addr_q[63:RSV_LSB]) rsv_valid <= 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        bus_req   = (state == RD) || (state == WR);
        bus_we    = (state == WR);
        bus_addr  = bus_req ? {addr_q[63:3], 3'b000} : '0;
        bus_bsel  = bus_req ? (q_mask << addr_q[2:0]) : '0;
        bus_wdata = bus_we ? ((wval_q & wmask) << {addr_q[2:0], 3'b000}) : '0;
        amo_mem   = (state == AMO_CALC) ? rd_q : '0;
        done      = (state == FIN) && !err_q;
        misalign  = (state == FIN) && err_q;
        rd_data   = done ? rd_q : '0;
    end

endmodule

// File: tb/tb_lsu_amo_engine.sv
// Randomized bench for lsu_amo_engine: byte-level memory model plus reservation
// model predicts results, bus traffic and latency for every operation.
module tb_lsu_amo_engine;

    localparam int unsigned RSV_LSB = 3;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  op = '0;
    logic [63:0] addr = '0, wdata = '0;
    logic [3:0]  size = 4'b0001;
    logic        unsign = 1'b0;
    logic [63:0] amo_mem, amo_result;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_bsel;
    logic        bus_ack = 1'b0;
    logic [63:0] bus_rdata = '0;
    logic        done, misalign;
    logic [63:0] rd_data;

    logic [63:0] alu_operand = '0;
    assign amo_result = amo_mem + alu_operand;

    lsu_amo_engine #(.RSV_LSB(RSV_LSB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .wdata(wdata), .size(size), .unsign(unsign),
        .amo_mem(amo_mem), .amo_result(amo_result),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_bsel(bus_bsel), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .done(done), .rd_data(rd_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memories: model side is byte-addressed, bus side word-addressed.
    logic [7:0]  mmem [longint];
    logic [63:0] bmem [longint];

    function automatic logic [7:0] byte_init(input longint a);
        logic [63:0] x;
        x = a * 64'h9E37_79B9_7F4A_7C15;
        return x[63:56];
    endfunction

    function automatic logic [7:0] mbyte(input longint a);
        return mmem.exists(a) ? mmem[a] : byte_init(a);
    endfunction

    function automatic logic [63:0] bword(input longint k);
        logic [63:0] w;
        if (bmem.exists(k)) return bmem[k];
        for (int i = 0; i < 8; i++) w[8*i +: 8] = byte_init(k * 8 + i);
        return w;
    endfunction

    task automatic poke_byte(input longint a, input logic [7:0] v);
        logic [63:0] w;
        mmem[a] = v;
        w = bword(a >>> 3);
        w[8*(a % 8) +: 8] = v;
        bmem[a >>> 3] = w;
    endtask

    // Bus responder with programmable wait states.
    int          wait_cfg = 0;
    int          ack_cnt = 0;
    int          n_rd = 0, n_wr = 0;
    logic [63:0] exp_baddr = '0, exp_wdata = '0;
    logic [7:0]  exp_bsel = '0;

    always @(negedge clk) begin
        if (!rst || !bus_req) begin
            bus_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            check_eq("bus_addr", bus_addr, exp_baddr);
            check_eq("bus_bsel", {56'd0, bus_bsel}, {56'd0, exp_bsel});
            if (bus_we) check_eq("bus_wdata", bus_wdata, exp_wdata);
            if (ack_cnt == wait_cfg) begin
                logic [63:0] w;
                longint k;
                k = longint'(bus_addr >> 3);
                w = bword(k);
                bus_rdata = w;
                if (bus_we) begin
                    for (int i = 0; i < 8; i++)
                        if (bus_bsel[i]) w[8*i +: 8] = bus_wdata[8*i +: 8];
                    bmem[k] = w;
                    n_wr++;
                end else n_rd++;
                bus_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                bus_ack = 1'b0;
                ack_cnt++;
            end
        end
    end

    // Reservation model.
    bit     rsv_v = 0;
    longint rsv_t = 0;

    task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] sz, input logic uns, input logic [63:0] operand,
                         input int wt);
        int n, off, exp_lat, exp_reads, exp_writes, got;
        bit misal, match, do_write;
        logic [63:0] old, lim, wv, exp_rd;
        n = (sz == 4'b0001) ? 1 : (sz == 4'b0010) ? 2 : (sz == 4'b0100) ? 4 : 8;
        off = int'(a[2:0]);
        misal = (a % n) != 0;
        match = rsv_v && (rsv_t == longint'(a >> RSV_LSB));
        old = '0;
        for (int i = 0; i < n; i++) old[8*i +: 8] = mbyte(longint'(a) + i);
        if (!uns && n < 8) begin
            lim = 64'd1 << (8 * n);
            if (old[8*n-1]) old = old | ~(lim - 64'd1);
        end
        exp_rd = '0; exp_reads = 0; exp_writes = 0; do_write = 0; wv = wd;
        exp_lat = 2;
        if (!misal) begin
            case (o)
                3'b000, 3'b010: begin
                    exp_rd = old; exp_reads = 1; exp_lat = 3 + wt;
                    if (o == 3'b010) begin rsv_v = 1; rsv_t = longint'(a >> RSV_LSB); end
                end
                3'b001: begin
                    do_write = 1; exp_lat = 3 + wt;
                    if (match) rsv_v = 0;
                end
                3'b011: begin
                    if (match) begin do_write = 1; exp_lat = 3 + wt; end
                    else exp_rd = 64'd1;
                    rsv_v = 0;
                end
                default: begin
                    exp_rd = old; exp_reads = 1; do_write = 1; exp_lat = 5 + 2 * wt;
                    wv = old + operand;
                    if (match) rsv_v = 0;
                end
            endcase
        end
        exp_wdata = '0;
        exp_bsel = '0;
        for (int i = 0; i < n; i++) begin
            exp_bsel[off + i] = 1'b1;
            exp_wdata[8*(off + i) +: 8] = wv[8*i +: 8];
        end
        if (do_write) begin
            exp_writes = 1;
            for (int i = 0; i < n; i++) mmem[longint'(a) + i] = wv[8*i +: 8];
        end
        exp_baddr = {a[63:3], 3'b000};
        alu_operand = operand;
        wait_cfg = wt;
        n_rd = 0; n_wr = 0;

        @(negedge clk);
        check_eq("req_ready", {63'd0, req_ready}, 64'd1);
        op = o; addr = a; wdata = wd; size = sz; unsign = uns; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (o == 3'b100 && !misal && k == 2 + wt) check_eq("amo_mem", amo_mem, old);
            if (done || misalign) begin got = k; break; end
        end
        if (got == 0) begin
            check_eq("completion_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("latency", 64'(got + 1), 64'(exp_lat));
        check_eq("done", {63'd0, done}, {63'd0, !misal});
        check_eq("misalign", {63'd0, misalign}, {63'd0, misal});
        if (!misal) check_eq("rd_data", rd_data, exp_rd);
        @(negedge clk);
        check_eq("pulse_width", {62'd0, done, misalign}, 64'd0);
        check_eq("bus_reads", 64'(n_rd), 64'(exp_reads));
        check_eq("bus_writes", 64'(n_wr), 64'(exp_writes));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        check_eq({tag, "_ctl"}, {60'd0, bus_req, bus_we, done, misalign}, 64'd0);
        check_eq({tag, "_data"}, rd_data | amo_mem | bus_addr | bus_wdata | {56'd0, bus_bsel}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        #2 rst = 1'b1;

        poke_byte(longint'(BASE + 5), 8'h80);
        do_op(3'b000, BASE + 64'd5, 64'd0, 4'b0001, 1'b0, 64'd0, 0);
        do_op(3'b001, BASE + 64'd20, 64'h1122_3344, 4'b0100, 1'b0, 64'd0, 0);
        poke_byte(longint'(BASE + 24), 8'h05);
        for (int i = 1; i < 8; i++) poke_byte(longint'(BASE + 24) + i, 8'h00);
        do_op(3'b100, BASE + 64'd24, 64'd0, 4'b1000, 1'b0, 64'd7, 0);
        do_op(3'b010, BASE + 64'd32, 64'd0, 4'b1000, 1'b0, 64'd0, 0);
        do_op(3'b011, BASE + 64'd32, 64'hDEAD_BEEF_0BAD_F00D, 4'b1000, 1'b0, 64'd0, 0);
        do_op(3'b011, BASE + 64'd32, 64'h1234, 4'b1000, 1'b0, 64'd0, 0);
        do_op(3'b010, BASE + 64'd32, 64'd0, 4'b1000, 1'b0, 64'd0, 1);
        do_op(3'b001, BASE + 64'd32, 64'h55, 4'b0001, 1'b0, 64'd0, 1);
        do_op(3'b011, BASE + 64'd32, 64'h66, 4'b1000, 1'b0, 64'd0, 0);
        do_op(3'b001, BASE + 64'd4, 64'h77, 4'b1000, 1'b0, 64'd0, 0);

        // Reset in the middle of a read whose ack is four cycles late.
        do_op(3'b010, BASE + 64'd40, 64'd0, 4'b1000, 1'b0, 64'd0, 0);
        wait_cfg = 4;
        exp_baddr = BASE + 64'd40;
        exp_bsel = 8'hFF;
        @(negedge clk);
        op = 3'b000; addr = BASE + 64'd40; size = 4'b1000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pre_busreq", {63'd0, bus_req}, 64'd1);
        #2 rst = 1'b0;
        #1 check_idle_outputs("rst_async");
        rsv_v = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", {62'd0, done, bus_req}, 64'd0);
        end
        do_op(3'b011, BASE + 64'd40, 64'h99, 4'b1000, 1'b0, 64'd0, 0);

        for (int t = 0; t < 300; t++) begin
            logic [2:0]  ro;
            logic [3:0]  rsz;
            logic [63:0] ra;
            int          nb;
            ro  = 3'($urandom_range(0, 4));
            rsz = 4'b0001 << $urandom_range(0, 3);
            nb  = (rsz == 4'b0001) ? 1 : (rsz == 4'b0010) ? 2 : (rsz == 4'b0100) ? 4 : 8;
            ra  = BASE + 64'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) ra = ra - (ra % nb);
            do_op(ro, ra, {$urandom, $urandom}, rsz, 1'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
